// File: rtl/mem_host_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_host_responder
//  Purpose  : Responder for the 512-bit host line interface. Each line read or
//             write is split into WORD_W-bit beats on a req/gnt/rvalid memory
//             port. Optional critical-word-first ordering: MEMRSP_CWF_EN.
//  Revision : 1.0  initial release
// ============================================================================
module mem_host_responder #(
    parameter int LINE_W = 512,
    parameter int WORD_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        op_host,
    input  logic [31:0]       AddrOut_host,
    input  logic [LINE_W-1:0] DataOut_host,
    output logic [LINE_W-1:0] DataIn_host,
    output logic              rd_valid_host,
    output logic              tx_done_host,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam int BEATS      = LINE_W / WORD_W;
    localparam int SLOT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W      = $clog2(WORD_W / 8);
    localparam int LINE_OFF_W = $clog2(LINE_W / 8);

    localparam logic [1:0]        OP_IDLE   = 2'b00;
    localparam logic [1:0]        OP_READ   = 2'b01;
    localparam logic [1:0]        OP_WRITE  = 2'b10;
    localparam logic [SLOT_W-1:0] LAST_BEAT = SLOT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        RESP     = 3'd4,
        DRAIN    = 3'd5
    } state_t;

    state_t              state_q;
    logic [31:0]         base_q;
    logic [SLOT_W-1:0]   beat_q;
    logic [SLOT_W-1:0]   start_q;
    logic [LINE_W-1:0]   wbuf_q;
    logic [SLOT_W-1:0]   start_d;
    logic [SLOT_W-1:0]   cur_slot;
    logic                unused_addr_bits;

`ifdef MEMRSP_CWF_EN
    assign start_d = AddrOut_host[OFF_W +: SLOT_W];
`else
    assign start_d = '0;
`endif

    // Byte-offset bits are meaningless to a line-granular requester.
    assign unused_addr_bits = ^AddrOut_host[LINE_OFF_W-1:0];

    // Slot wraps naturally because BEATS is a power of two.
    assign cur_slot  = beat_q + start_q;
    assign mem_addr  = base_q + (32'(cur_slot) << OFF_W);
    assign mem_wdata = wbuf_q[cur_slot*WORD_W +: WORD_W];
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            base_q        <= '0;
            beat_q        <= '0;
            start_q       <= '0;
            wbuf_q        <= '0;
            DataIn_host   <= '0;
            rd_valid_host <= 1'b0;
            tx_done_host  <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_host == OP_READ || op_host == OP_WRITE) begin
                        base_q  <= {AddrOut_host[31:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
                        start_q <= start_d;
                        beat_q  <= '0;
                        mem_req <= 1'b1;
                        if (op_host == OP_WRITE) begin
                            wbuf_q  <= DataOut_host;
                            mem_we  <= 1'b1;
                            state_q <= WR_ISSUE;
                        end else begin
                            state_q <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        DataIn_host[cur_slot*WORD_W +: WORD_W] <= mem_rdata;
                        if (beat_q == LAST_BEAT) begin
                            tx_done_host  <= 1'b1;
                            rd_valid_host <= 1'b1;
                            state_q       <= RESP;
                        end else begin
                            beat_q  <= beat_q + SLOT_W'(1);
                            mem_req <= 1'b1;
                            state_q <= RD_ISSUE;
                        end
                    end
                end
                WR_ISSUE: begin
                    if (mem_gnt) begin
                        if (beat_q == LAST_BEAT) begin
                            mem_req      <= 1'b0;
                            mem_we       <= 1'b0;
                            tx_done_host <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            beat_q <= beat_q + SLOT_W'(1);
                        end
                    end
                end
                RESP: begin
                    tx_done_host  <= 1'b0;
                    rd_valid_host <= 1'b0;
                    // A requester still holding op must release it before re-service.
                    state_q       <= (op_host == OP_IDLE) ? IDLE : DRAIN;
                end
                DRAIN: begin
                    if (op_host == OP_IDLE) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_host_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_host_responder
//  Purpose  : Self-checking bench for mem_host_responder with a memory agent
//             and a line-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_host_responder;

    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   op_host;
    logic [31:0]  AddrOut_host;
    logic [511:0] DataOut_host;
    logic [511:0] DataIn_host;
    logic         rd_valid_host;
    logic         tx_done_host;
    logic         busy;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [63:0]  mem_rdata;

    always #5 clk = ~clk;

    mem_host_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_host      (op_host),
        .AddrOut_host (AddrOut_host),
        .DataOut_host (DataOut_host),
        .DataIn_host  (DataIn_host),
        .rd_valid_host(rd_valid_host),
        .tx_done_host (tx_done_host),
        .busy         (busy),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [63:0] wdata;
    } beat_t;

    typedef struct {
        logic [1:0]   op;
        logic [31:0]  addr;
        logic [511:0] wl;
        int           gw;
        int           hold;
        logic [31:0]  salt;
        int           lat;
    } vec_t;

    int           n_checks = 0;
    int           n_fail   = 0;
    beat_t        beat_log[$];
    bit           agent_en = 1'b1;
    int           gnt_wait = 0;
    logic [31:0]  salt = '0;
    bit           addr_unstable = 1'b0;
    logic [511:0] cur_line = '0;
    vec_t         vecs[7];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Reference model: line-level view of beat ordering and read data.
    function automatic logic [31:0] model_addr(input logic [31:0] a, input int i);
        int start;
`ifdef MEMRSP_CWF_EN
        start = int'(a[5:3]);
`else
        start = 0;
`endif
        return (a & 32'hFFFF_FFC0) + 32'(((start + i) % 8) * 8);
    endfunction

    function automatic logic [511:0] model_line(input logic [31:0] a, input logic [31:0] s);
        logic [511:0] l;
        l = '0;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = {s, (a & 32'hFFFF_FFC0) + 32'(k * 8)};
        return l;
    endfunction

    // Memory agent: grants after gnt_wait idle-request cycles, returns rvalid one cycle later.
    initial begin
        int          wcnt;
        bit          rv_pend;
        logic [31:0] rv_addr;
        logic [31:0] req_addr;
        beat_t       b;
        wcnt = 0; rv_pend = 1'b0; rv_addr = '0; req_addr = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (agent_en) begin
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b0;
                if (!rst_n) begin
                    rv_pend = 1'b0;
                    wcnt    = 0;
                end else begin
                    if (rv_pend) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = {salt, rv_addr};
                        rv_pend    = 1'b0;
                    end
                    if (mem_req) begin
                        if (wcnt > 0 && mem_addr !== req_addr) addr_unstable = 1'b1;
                        req_addr = mem_addr;
                        if (wcnt >= gnt_wait) begin
                            mem_gnt = 1'b1;
                            wcnt    = 0;
                            b.addr = mem_addr; b.we = mem_we; b.wdata = mem_wdata;
                            beat_log.push_back(b);
                            if (!mem_we) begin
                                rv_pend = 1'b1;
                                rv_addr = mem_addr;
                            end
                        end else begin
                            wcnt++;
                        end
                    end else begin
                        wcnt = 0;
                    end
                end
            end
        end
    end

    task automatic run_txn(input vec_t v);
        int          cyc;
        bit          seen;
        logic [31:0] a;
        int          slot;
        beat_log.delete();
        gnt_wait      = v.gw;
        salt          = v.salt;
        addr_unstable = 1'b0;
        @(negedge clk);
        check("idle_before_accept", busy, 1'b0);
        op_host = v.op; AddrOut_host = v.addr; DataOut_host = v.wl;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                AddrOut_host = ~v.addr;
                DataOut_host = ~v.wl;
            end
            seen = (tx_done_host === 1'b1);
        end
        check("tx_done_latency", cyc, v.lat);
        check("rd_valid_at_done", rd_valid_host, v.op == OP_RD);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            check("drain_busy", busy, 1'b1);
            check("drain_no_req", {mem_req, tx_done_host}, 2'b00);
        end
        op_host = 2'b00;
        @(negedge clk);
        check("return_idle", {busy, tx_done_host, rd_valid_host, mem_req}, 4'b0000);
        if (v.op == OP_RD) cur_line = model_line(v.addr, v.salt);
        check("line_data", DataIn_host, cur_line);
        check("beat_count", beat_log.size(), 8);
        for (int i = 0; i < 8 && i < beat_log.size(); i++) begin
            a    = model_addr(v.addr, i);
            slot = int'(a[5:3]);
            check("beat_addr", beat_log[i].addr, a);
            check("beat_we", beat_log[i].we, v.op == OP_WR);
            if (v.op == OP_WR) check("beat_wdata", beat_log[i].wdata, v.wl[slot*64 +: 64]);
        end
        check("addr_stable_in_wait", addr_unstable, 1'b0);
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        logic [511:0] w2;
        vec_t         rv;
        op_host = 2'b00; AddrOut_host = '0; DataOut_host = '0;

        repeat (3) @(negedge clk);
        check("reset_data_in", DataIn_host, '0);
        check("reset_pulses", {rd_valid_host, tx_done_host}, 2'b00);
        check("reset_busy", busy, 1'b0);
        check("reset_mem_ctl", {mem_req, mem_we}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 8; k++) w2[k*64 +: 64] = 64'((k + 1) * 17);
        vecs[0] = '{OP_RD, 32'h0600_2044, '0,          0, 0, 32'h0,         17};
        vecs[1] = '{OP_RD, 32'h0600_2064, '0,          0, 0, 32'h0,         17};
        vecs[2] = '{OP_WR, 32'h0600_3000, w2,          0, 0, 32'h0,          9};
        vecs[3] = '{OP_RD, 32'h0600_4018, '0,          3, 0, 32'hCAFE_F00D, 41};
        vecs[4] = '{OP_WR, 32'h0600_507C, rand_line(), 1, 0, 32'h0,         17};
        vecs[5] = '{OP_RD, 32'h0600_1000, '0,          0, 5, 32'h1234_5678, 17};
        vecs[6] = '{OP_WR, 32'h0600_3040, rand_line(), 0, 0, 32'h0,          9};
        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // Reserved op and spurious memory handshakes while idle.
        @(negedge clk);
        op_host = OP_RSV; AddrOut_host = 32'h0600_8000;
        repeat (4) begin
            @(negedge clk);
            check("reserved_op_idle", {busy, mem_req}, 2'b00);
        end
        agent_en = 1'b0;
        repeat (3) begin
            mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = {$urandom, $urandom};
            @(negedge clk);
            check("spurious_idle", {busy, mem_req, tx_done_host, rd_valid_host}, 4'b0000);
            check("spurious_data", DataIn_host, cur_line);
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        agent_en = 1'b1;
        op_host = 2'b00;

        // Reset while beat 4 of a read is being requested.
        beat_log.delete();
        gnt_wait = 0; salt = 32'h0BAD_BEEF;
        @(negedge clk);
        op_host = OP_RD; AddrOut_host = 32'h0600_7010;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            #1;
            if (beat_log.size() >= 5) break;
        end
        check("pre_reset_req", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_async_ctl", {mem_req, busy, tx_done_host, rd_valid_host}, 4'b0000);
        check("rst_async_data", DataIn_host, '0);
        cur_line = '0;
        op_host = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_txn('{OP_RD, 32'h0600_7010, '0, 0, 0, 32'h0BAD_BEEF, 17});

        for (int i = 0; i < 24; i++) begin
            rv.op   = ($urandom_range(0, 1) == 0) ? OP_RD : OP_WR;
            rv.addr = $urandom;
            rv.wl   = rand_line();
            rv.gw   = $urandom_range(0, 2);
            rv.hold = $urandom_range(0, 2);
            rv.salt = $urandom;
            rv.lat  = ((rv.op == OP_RD) ? 17 : 9) + 8 * rv.gw;
            run_txn(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_host_responder.md
Name: mem_host_responder

Overview:
- Responder end of the 512-bit host line interface that the fetch and data memory systems drive (`op_host`, `AddrOut_host`, `DataOut_host` in; `DataIn_host`, `rd_valid_host`, `tx_done_host` out).
- Accepts one line read or line write at a time.
- Splits each line into WORD_W-bit beats on a simple req/gnt/rvalid backing-memory port, reassembles read data, and signals completion.
- Sits between a `mem_system` instance and the external memory bridge.

Parameters:
- LINE_W, 512, line width in bits. Fixed to match the host interface.
- WORD_W, 64, backing-memory beat width. BEATS = LINE_W/WORD_W = 8. LINE_W must be a multiple of WORD_W and BEATS a power of two.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- op_host  in  2  00 idle, 01 line read, 10 line write, 11 reserved
- AddrOut_host  in  32  byte address of request
- DataOut_host  in  512  write line
- DataIn_host  out  512  read line
- rd_valid_host  out  1  read line valid pulse
- tx_done_host  out  1  transaction complete pulse
- busy  out  1  high in any state other than IDLE
- mem_req  out  1  beat request
- mem_we  out  1  beat is a write
- mem_addr  out  32  beat byte address
- mem_wdata  out  WORD_W  write beat
- mem_gnt  in  1  beat accepted this cycle
- mem_rvalid  in  1  read beat data valid
- mem_rdata  in  WORD_W  read beat data

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - All outputs reset to 0, including DataIn_host.
  - State returns to IDLE and the beat counter clears.
  - Reset mid-transaction abandons the transaction. mem_req drops asynchronously and no tx_done is produced.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP, DRAIN.
- IDLE:
  - op 01 → latch base = {AddrOut_host[31:6], 6'b0}, clear beat index, go to RD_ISSUE.
  - op 10 → also latch DataOut_host into the write buffer, go to WR_ISSUE.
  - op 00 or 11 → stay in IDLE. Reserved op is ignored.
- Beat address: mem_addr = base + slot*(WORD_W/8), where slot is the line slot of the current beat.
- RD_ISSUE:
  - mem_req=1, mem_we=0.
  - Hold until mem_gnt, then go to RD_WAIT.
- RD_WAIT:
  - mem_req=0.
  - On mem_rvalid, write mem_rdata into DataIn_host[slot*WORD_W +: WORD_W].
  - If that was the last beat, go to RESP; otherwise increment and go to RD_ISSUE.
- Only one outstanding beat at a time. mem_rvalid outside RD_WAIT and mem_gnt while mem_req=0 are ignored.
- WR_ISSUE:
  - mem_req=1, mem_we=1, mem_wdata = buffer slice for the current slot.
  - Each mem_gnt advances one beat; back-to-back gnt gives one beat per cycle.
  - After the last gnt, go to RESP.
- RESP (exactly one cycle):
  - tx_done_host=1.
  - rd_valid_host=1 only for reads.
  - Then go to DRAIN.
- DRAIN:
  - Wait for op_host==00, then go to IDLE.
  - A requester still holding op after tx_done is never re-serviced.
  - If op is already 00 in the RESP cycle, go RESP → IDLE directly.
- DataIn_host:
  - Changes only during read fills.
  - Holds the last completed line across writes and idle.
- Latency with zero-wait memory (gnt in the req cycle, rvalid one cycle after gnt):
  - Read: tx_done 17 cycles after the IDLE accept edge.
  - Write: tx_done 9 cycles after the IDLE accept edge.
- Inputs other than op are sampled only at accept. Changes to AddrOut_host/DataOut_host mid-transaction have no effect.

Optional Feature:
- MEMRSP_CWF_EN defined (critical word first):
  - Reads and writes start at slot AddrOut_host[5:3] (log2 BEATS bits above the WORD_W byte offset).
  - Slots wrap modulo BEATS; all 8 beats are still transferred.
  - Data always lands in its natural slot.
- Undefined: slots run 0..BEATS-1 in order.
- Latency is identical in both cases.

Test Plan:
1. Read at addr 0x06002044, zero-wait memory returning rdata = mem_addr zero-extended → mem_addr sequence 0x06002040, 0x06002048 … 0x06002078. tx_done and rd_valid pulse one cycle at accept+17. DataIn_host slot k = 0x06002040+8k. With MEMRSP_CWF_EN the sequence starts at 0x06002040 (slot 0); with addr 0x06002064 it starts 0x06002060 and wraps to 0x06002040.
2. Write line of slots 0x11..0x88 at 0x06003000 with gnt held high → 8 consecutive cycles of mem_req=mem_we=1, mem_wdata 0x11 … 0x88 at 0x06003000 … 0x06003038. tx_done at accept+9, rd_valid stays 0, DataIn_host unchanged.
3. Memory backpressure: gnt low 3 cycles per beat on a read → mem_req held, mem_addr stable while waiting. Line correct; tx_done at accept+41.
4. op_host held at 01 for 5 cycles after tx_done → busy=1 in DRAIN, no new mem_req. op→00 then 10 → write accepted normally.
5. op 11 in IDLE → no mem_req, busy=0. Spurious mem_rvalid/mem_gnt in IDLE → no state or output change.
6. rst_n low during beat 4 of a read → mem_req, busy, tx_done, DataIn_host go to 0 immediately. After release, a new read completes normally.
